// File: rtl/axbs_share_arb.sv
// ---------------------------------------------------------------------------
// axbs_share_arb
// Shares a single pipelined signed multiplier (axbs, fixed MUL_LATENCY) among
// NUM_REQ requesters. A round-robin arbiter issues one operand pair per clock
// into a registered issue stage that drives the multiplier. A tag pipeline of
// {valid,id} travels alongside each product, so every result leaving the
// multiplier is broadcast with the ID of the requester that issued it.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active-high
//   req_valid  [NUM_REQ]           requester i holds an operand pair
//   req_a      [NUM_REQ*SIZE_A]    operand A, requester i at [i*SIZE_A +: SIZE_A]
//   req_b      [NUM_REQ*SIZE_B]    operand B, requester i at [i*SIZE_B +: SIZE_B]
//   req_ready  [NUM_REQ]           one-hot grant (transfer on valid & ready)
//   mul_a      [SIZE_A]            registered operand A to axbs din_a
//   mul_b      [SIZE_B]            registered operand B to axbs din_b
//   mul_dout   [SIZE_A+SIZE_B]     axbs dout
//   res_valid                      res_id/res_data valid this cycle
//   res_id     [ID_W]              requester that issued this product
//   res_data   [SIZE_A+SIZE_B]     signed product, straight from mul_dout
//   busy                           any product in flight
// ---------------------------------------------------------------------------
module axbs_share_arb #(
  parameter int NUM_REQ     = 4,
  parameter int SIZE_A      = 27,
  parameter int SIZE_B      = 27,
  parameter int MUL_LATENCY = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*SIZE_A-1:0]   req_a,
  input  logic [NUM_REQ*SIZE_B-1:0]   req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [SIZE_A-1:0]           mul_a,
  output logic [SIZE_B-1:0]           mul_b,
  input  logic [SIZE_A+SIZE_B-1:0]    mul_dout,
  output logic                        res_valid,
  output logic [ID_W-1:0]             res_id,
  output logic [SIZE_A+SIZE_B-1:0]    res_data,
  output logic                        busy
);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               found;
  logic [ID_W-1:0]    scan_idx;
  tag_t               issue_tag;
  tag_t               tag_pipe [MUL_LATENCY];
  logic               any_tag_vld;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ, so the
  // pointer and scan index stay below NUM_REQ even for non-power-of-2 counts.
  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_id        = scan_idx;
      end
    end
  end

  // No grant is visible while reset holds the issue logic cleared.
  assign req_ready = rst ? '0 : grant;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the tag shift register moves one stage per clock.
  // NOTE: the tag array is reset, not just its valid bits, because res_id has
  // a defined reset value and is taken straight from the tail entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      issue_tag <= '0;
      for (int k = 0; k < MUL_LATENCY; k++) tag_pipe[k] <= '0;
    end else begin
      if (found) begin
        rr_ptr    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        mul_a     <= req_a[int'(grant_id)*SIZE_A +: SIZE_A];
        mul_b     <= req_b[int'(grant_id)*SIZE_B +: SIZE_B];
        issue_tag <= '{vld: 1'b1, id: grant_id};
      end else begin
        // Operands hold to avoid needless toggling at the multiplier input.
        issue_tag.vld <= 1'b0;
      end
      // Issue register plus MUL_LATENCY stages lines the tail up with mul_dout.
      tag_pipe[0] <= issue_tag;
      for (int k = 1; k < MUL_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  always_comb begin
    any_tag_vld = 1'b0;
    for (int k = 0; k < MUL_LATENCY; k++) any_tag_vld = any_tag_vld | tag_pipe[k].vld;
  end

  assign res_valid = tag_pipe[MUL_LATENCY-1].vld;
  assign res_id    = tag_pipe[MUL_LATENCY-1].id;
  assign res_data  = mul_dout;
  assign busy      = issue_tag.vld | any_tag_vld;

endmodule

// File: tb/tb_axbs_share_arb.sv
// ---------------------------------------------------------------------------
// tb_axbs_share_arb
// Directed bench for axbs_share_arb with a behavioural stand-in for the axbs
// multiplier (registered signed product, MUL_LATENCY deep). Expected values
// are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_axbs_share_arb;

  localparam int NUM_REQ = 4;
  localparam int SIZE_A  = 27;
  localparam int SIZE_B  = 27;
  localparam int LAT     = 4;
  localparam int ID_W    = 2;
  localparam int PW      = SIZE_A + SIZE_B;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*SIZE_A-1:0]  req_a;
  logic [NUM_REQ*SIZE_B-1:0]  req_b;
  logic [NUM_REQ-1:0]         req_ready;
  logic [SIZE_A-1:0]          mul_a;
  logic [SIZE_B-1:0]          mul_b;
  logic [PW-1:0]              mul_dout;
  logic                       res_valid;
  logic [ID_W-1:0]            res_id;
  logic [PW-1:0]              res_data;
  logic                       busy;

  int checks = 0;
  int errors = 0;

  axbs_share_arb #(
    .NUM_REQ(NUM_REQ), .SIZE_A(SIZE_A), .SIZE_B(SIZE_B), .MUL_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: keeps running through reset, like the real DSP.
  logic signed [PW-1:0] mpipe [LAT];
  initial for (int k = 0; k < LAT; k++) mpipe[k] = '0;
  always @(posedge clk) begin
    mpipe[0] <= $signed(mul_a) * $signed(mul_b);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_dout = mpipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [SIZE_A-1:0] a, input logic [SIZE_B-1:0] b);
    req_a[i*SIZE_A +: SIZE_A] = a;
    req_b[i*SIZE_B +: SIZE_B] = b;
  endtask

  // Products of the per-requester operands used in the contention run:
  // 100*7, 101*4, 102*1, 103*-2
  int prod_tbl [NUM_REQ] = '{700, 404, 102, -206};

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, SIZE_A'(100 + i), SIZE_B'(7 - 3*i));

    // Reset with all requesters valid
    tick();
    tick();
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_res_valid", 64'(res_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_res_id", 64'(res_id), 64'h0);
    check("rst_mul_a", 64'(mul_a), 64'h0);

    // Release, then hold all valid for 8 cycles: strict rotation, results back-to-back
    rst = 1'b0;
    for (int n = 0; n < 14; n++) begin
      req_valid = (n < 8) ? 4'hF : 4'h0;
      #1;
      check($sformatf("rot_ready_%0d", n), 64'(req_ready),
            (n < 8) ? 64'(1 << (n % 4)) : 64'h0);
      if (n == 1) check("rot_busy", 64'(busy), 64'h1);
      if (n >= 5 && n < 13) begin
        check($sformatf("rot_valid_%0d", n), 64'(res_valid), 64'h1);
        check($sformatf("rot_id_%0d", n), 64'(res_id), 64'((n - 5) % 4));
        check($sformatf("rot_data_%0d", n), $signed(res_data), 64'(prod_tbl[(n - 5) % 4]));
      end else begin
        check($sformatf("rot_idle_%0d", n), 64'(res_valid), 64'h0);
      end
      tick();
    end
    check("drain_busy", 64'(busy), 64'h0);

    // Single request: req1 3 * -5
    set_op(1, SIZE_A'(3), SIZE_B'(-5));
    req_valid = 4'b0010;
    #1;
    check("single_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'h0;
    for (int m = 1; m <= 6; m++) begin
      #1;
      if (m == 1) check("single_busy", 64'(busy), 64'h1);
      check($sformatf("single_valid_%0d", m), 64'(res_valid), (m == 5) ? 64'h1 : 64'h0);
      if (m == 5) begin
        check("single_id", 64'(res_id), 64'h1);
        check("single_data", $signed(res_data), -64'sd15);
      end
      tick();
    end

    // Skip: rr_ptr is 2, only 0 and 1 request -> wrap to 0, then 1, pointer ends at 2
    req_valid = 4'b0011;
    #1;
    check("skip_ready0", 64'(req_ready), 64'h1);
    tick();
    #1;
    check("skip_ready1", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b1000;
    #1;
    check("drop_ready3", 64'(req_ready), 64'h8);
    req_valid = 4'h0;
    #1;
    check("none_ready", 64'(req_ready), 64'h0);
    req_valid = 4'hF;
    #1;
    check("skip_ptr2", 64'(req_ready), 64'h4);
    req_valid = 4'h0;
    for (int m = 0; m < 7; m++) tick();

    // Extremes on req0, issued on consecutive cycles
    req_valid = 4'b0001;
    set_op(0, 27'h4000000, 27'h4000000);   // -2^26 * -2^26
    #1;
    check("ext_ready0", 64'(req_ready), 64'h1);
    tick();
    set_op(0, 27'h3FFFFFF, 27'h4000000);   // (2^26-1) * -2^26
    #1;
    check("ext_ready1", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'h0;
    tick();
    tick();
    tick();
    check("ext_valid0", 64'(res_valid), 64'h1);
    check("ext_data0", $signed(res_data), 64'sd4503599627370496);
    tick();
    check("ext_valid1", 64'(res_valid), 64'h1);
    check("ext_id1", 64'(res_id), 64'h0);
    check("ext_data1", $signed(res_data), -64'sd4503599560261632);
    tick();
    check("ext_after", 64'(res_valid), 64'h0);

    // Mid-flight reset: pointer is 1, issue 1,2,0 then reset 2 cycles later
    req_valid = 4'b0111;
    #1;
    check("mf_ready0", 64'(req_ready), 64'h2);
    tick();
    #1;
    check("mf_ready1", 64'(req_ready), 64'h4);
    tick();
    #1;
    check("mf_ready2", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'h0;
    tick();
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    check("mf_rst_ready", 64'(req_ready), 64'h0);
    check("mf_rst_busy", 64'(busy), 64'h0);
    check("mf_rst_valid", 64'(res_valid), 64'h0);
    tick();
    rst = 1'b0;
    req_valid = 4'h0;
    for (int m = 0; m < 8; m++) begin
      #1;
      check($sformatf("mf_valid_%0d", m), 64'(res_valid), 64'h0);
      tick();
    end
    check("mf_busy", 64'(busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
